// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM: fetch, decode, execute, memory and write-back sequencing.
// Optional MC_CTRL_ILLEGAL_TRAP_EN sends illegal instructions to a sticky TRAP state instead of refetching.
module mc_controller #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       zero,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       aluSrc,
  output logic [1:0] regDst,
  output logic [1:0] memToR,
  output logic [2:0] aluOp,
  output logic [1:0] extOp,
  output logic [2:0] jumpOp,
  output logic [2:0] state,
  output logic       instrDone,
  output logic       illegal
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_ORI, I_LW, I_SW, I_BEQ, I_JR, I_LUI, I_JAL, I_BAD
  } instr_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [5:0]       op_q, fn_q;
  instr_t           cls_in, cls_q;

  function automatic instr_t classify(input logic [5:0] o, input logic [5:0] f);
    instr_t c;
    c = I_BAD;
    case (o)
      6'b000000: begin
        case (f)
          6'b100000: c = I_ADD;
          6'b100010: c = I_SUB;
          6'b001000: c = I_JR;
          default:   c = I_BAD;
        endcase
      end
      6'b001101: c = I_ORI;
      6'b100011: c = I_LW;
      6'b101011: c = I_SW;
      6'b000100: c = I_BEQ;
      6'b001111: c = I_LUI;
      6'b000011: c = I_JAL;
      default:   c = I_BAD;
    endcase
    return c;
  endfunction

  // DECODE steers on the live IR fields; later states use only the latched copy.
  assign cls_in = classify(op, fn);
  assign cls_q  = classify(op_q, fn_q);
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == DECODE) begin
        op_q <= op;
        fn_q <= fn;
      end
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic ill_q;

  always_ff @(posedge clk) begin
    if (reset)                ill_q <= 1'b0;
    else if (state_d == TRAP) ill_q <= 1'b1;
  end

  assign illegal = ill_q & ~reset;
`else
  assign illegal = 1'b0;
`endif

  // Next state and decoded strobes; wait_d defaults to 0 so FETCH/MEM are always entered with a clear counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    aluSrc    = 1'b0;
    regDst    = 2'b00;
    memToR    = 2'b00;
    aluOp     = 3'b000;
    extOp     = 2'b00;
    jumpOp    = 3'b000;
    instrDone = 1'b0;

    case (state_q)
      FETCH: begin
        memRead = 1'b1;
        if (wait_q == LAST_CNT) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = DECODE;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      DECODE: begin
        case (cls_in)
          I_LUI, I_JAL: state_d = WB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          I_BAD:        state_d = TRAP;
`else
          I_BAD:        state_d = FETCH;
`endif
          default:      state_d = EXEC;
        endcase
      end

      EXEC: begin
        state_d = FETCH;
        case (cls_q)
          I_ADD: state_d = WB;
          I_SUB: begin
            aluOp   = 3'b001;
            state_d = WB;
          end
          I_ORI: begin
            aluSrc  = 1'b1;
            aluOp   = 3'b011;
            state_d = WB;
          end
          I_LW, I_SW: begin
            aluSrc  = 1'b1;
            extOp   = 2'b01;
            state_d = MEM;
          end
          I_BEQ: begin
            aluOp     = 3'b100;
            jumpOp    = 3'b001;
            pcWrite   = zero;
            instrDone = 1'b1;
          end
          I_JR: begin
            jumpOp    = 3'b011;
            pcWrite   = 1'b1;
            instrDone = 1'b1;
          end
          default: state_d = FETCH;
        endcase
      end

      MEM: begin
        memRead = (cls_q == I_LW);
        if (wait_q == LAST_CNT) begin
          if (cls_q == I_LW) begin
            state_d = WB;
          end else begin
            memWrite  = 1'b1;
            instrDone = 1'b1;
            state_d   = FETCH;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      WB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        state_d   = FETCH;
        case (cls_q)
          I_ADD, I_SUB: regDst = 2'b01;
          I_LW:         memToR = 2'b01;
          I_LUI: begin
            extOp  = 2'b10;
            memToR = 2'b10;
          end
          I_JAL: begin
            regDst  = 2'b10;
            memToR  = 2'b11;
            pcWrite = 1'b1;
            jumpOp  = 3'b010;
          end
          default: ;
        endcase
      end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`else
      TRAP: state_d = FETCH;
`endif

      default: state_d = FETCH;
    endcase

    // Synchronous reset still silences every strobe during the reset cycle itself.
    if (reset) begin
      pcWrite   = 1'b0;
      irWrite   = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      aluSrc    = 1'b0;
      regDst    = 2'b00;
      memToR    = 2'b00;
      aluOp     = 3'b000;
      extOp     = 2'b00;
      jumpOp    = 3'b000;
      instrDone = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of mc_controller with MEM_LAT=2; follows MC_CTRL_ILLEGAL_TRAP_EN if defined.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] fn;
  logic       zero;
  logic       pcWrite, irWrite, memRead, memWrite, regWrite, aluSrc;
  logic [1:0] regDst, memToR, extOp;
  logic [2:0] aluOp, jumpOp, state;
  logic       instrDone, illegal;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc_n    = 0;
  string cur_tag  = "";
  logic [5:0] cur_op = '0;
  logic [5:0] cur_fn = '0;
  logic       cur_z  = 1'b0;

  mc_controller #(.MEM_LAT(2), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .op(op), .fn(fn), .zero(zero),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .aluSrc(aluSrc), .regDst(regDst), .memToR(memToR),
    .aluOp(aluOp), .extOp(extOp), .jumpOp(jumpOp), .state(state),
    .instrDone(instrDone), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {pcWrite, irWrite, memRead, memWrite, regWrite, aluSrc, regDst, memToR,
                aluOp, extOp, jumpOp, state, instrDone, illegal};

  // sb = {pcWrite, irWrite, memRead, memWrite, regWrite, aluSrc}
  function automatic logic [22:0] v(input logic [2:0] st, input logic [5:0] sb,
                                    input logic [1:0] rd, input logic [1:0] mr,
                                    input logic [2:0] alu, input logic [1:0] ext,
                                    input logic [2:0] jmp, input logic done, input logic ill);
    return {sb, rd, mr, alu, ext, jmp, st, done, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input logic rst, input logic [22:0] e);
    @(negedge clk);
    reset = rst;
    op    = cur_op;
    fn    = cur_fn;
    zero  = cur_z;
    #2;
    check($sformatf("%s_c%0d", cur_tag, cyc_n), 32'(obs), 32'(e));
    cyc_n++;
  endtask

  task automatic instr(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z);
    cur_tag = tag;
    cur_op  = o;
    cur_fn  = f;
    cur_z   = z;
    cyc_n   = 0;
  endtask

  task automatic fetch_decode();
    cyc(1'b0, v(3'd0, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd0, 6'b111000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd1, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
  endtask

  initial begin
    reset = 1'b1;
    op    = '0;
    fn    = '0;
    zero  = 1'b0;

    instr("reset", 6'd0, 6'd0, 1'b0);
    cyc(1'b1, v(3'd0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b1, v(3'd0, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));

    // add; IR is scrambled after DECODE to show EXEC/WB use the latched fields
    instr("add", 6'b000000, 6'b100000, 1'b0);
    fetch_decode();
    cur_op = 6'b111111;
    cur_fn = 6'b111111;
    cyc(1'b0, v(3'd2, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd4, 6'b000010, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));

    instr("sub", 6'b000000, 6'b100010, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000000, 2'b00, 2'b00, 3'b001, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd4, 6'b000010, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));

    instr("ori", 6'b001101, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000001, 2'b00, 2'b00, 3'b011, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd4, 6'b000010, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));

    instr("lw", 6'b100011, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd3, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd3, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd4, 6'b000010, 2'b00, 2'b01, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));

    instr("sw", 6'b101011, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd3, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd3, 6'b000100, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));

    instr("beq_z1", 6'b000100, 6'b000000, 1'b1);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b100000, 2'b00, 2'b00, 3'b100, 2'b00, 3'b001, 1'b1, 1'b0));

    instr("beq_z0", 6'b000100, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000000, 2'b00, 2'b00, 3'b100, 2'b00, 3'b001, 1'b1, 1'b0));

    instr("jr", 6'b000000, 6'b001000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b100000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b011, 1'b1, 1'b0));

    instr("lui", 6'b001111, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd4, 6'b000010, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 1'b1, 1'b0));

    instr("jal", 6'b000011, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd4, 6'b100010, 2'b10, 2'b11, 3'b000, 2'b00, 3'b010, 1'b1, 1'b0));

    instr("illegal", 6'b111111, 6'b000000, 1'b0);
    fetch_decode();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      cyc(1'b0, v(3'd5, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b1));
    cyc(1'b1, v(3'd5, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
`endif

    // sw interrupted by reset on the first MEM cycle; write must never appear
    instr("sw_rst", 6'b101011, 6'b000000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000001, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd3, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b1, v(3'd3, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));

    // recovery: full fetch with a cleared counter, and op_q cleared so a bare EXEC is not possible
    instr("post_rst_add", 6'b000000, 6'b100000, 1'b0);
    fetch_decode();
    cyc(1'b0, v(3'd2, 6'b000000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));
    cyc(1'b0, v(3'd4, 6'b000010, 2'b01, 2'b00, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0));
    cyc(1'b0, v(3'd0, 6'b001000, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
